adaptive_beam_safety_supervisor: RTL and testbench

//  Parametrised safety supervisor for the beam-steering unit: debounces N_SENS interlock sensors,

---
 rtl/absu_pkg.sv | 24 ++
 rtl/absu_debounce.sv | 33 +++
 rtl/adaptive_beam_safety_supervisor.sv | 146 ++++++++++++++
 tb/tb_adaptive_beam_safety_supervisor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/absu_pkg.sv
// Shared types and default channel masks for the adaptive beam safety supervisor.
package absu_pkg;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_NORMAL = 3'd1,
    S_WARN   = 3'd2,
    S_FAULT  = 3'd3,
    S_EMG    = 3'd4,
    S_LOCK   = 3'd5
  } state_t;

  typedef struct packed {
    logic emg;
    logic fault;
    logic warn;
  } class_t;

  localparam logic [5:0] DEF_EMG_MASK   = 6'b100010;
  localparam logic [5:0] DEF_FAULT_MASK = 6'b000101;
  localparam logic [5:0] DEF_WARN_MASK  = 6'b011000;
  localparam logic [5:0] DEF_GANTRY_INH = 6'b010000;

endpackage

// File: rtl/absu_debounce.sv
// Single-channel debouncer: the output follows the input only after DEB_CYCLES
// consecutive disagreeing samples.
module absu_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (raw != deb) begin
      if (cnt == LAST) begin
        deb <= raw;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/adaptive_beam_safety_supervisor.sv
// Beam-steering safety supervisor: debounced sensor classification, 6-state
// safety FSM with warning escalation, acknowledged emergency exit and fault lockout.
module adaptive_beam_safety_supervisor
  import absu_pkg::*;
#(
  parameter int unsigned        N_SENS     = 6,
  parameter int unsigned        DEB_CYCLES = 4,
  parameter int unsigned        ESC_CYCLES = 1000,
  parameter int unsigned        MAX_FAULTS = 3,
  parameter logic [N_SENS-1:0]  EMG_MASK   = DEF_EMG_MASK,
  parameter logic [N_SENS-1:0]  FAULT_MASK = DEF_FAULT_MASK,
  parameter logic [N_SENS-1:0]  WARN_MASK  = DEF_WARN_MASK,
  parameter logic [N_SENS-1:0]  GANTRY_INH = DEF_GANTRY_INH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_SENS-1:0]                    sens_raw,
  input  logic                                 emg_ack,
  output logic                                 y_table,
  output logic                                 y_gantry,
  output logic                                 y_filter,
  output logic                                 y_fan,
  output logic                                 y_shutter,
  output logic                                 y_relay_iso,
  output logic [N_SENS-1:0]                    sens_deb,
  output logic [$clog2(MAX_FAULTS+1)-1:0]      fault_cnt,
  output logic [2:0]                           state_dbg
);

  localparam int unsigned IW  = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int unsigned EW  = $clog2(ESC_CYCLES + 1);
  localparam int unsigned FCW = $clog2(MAX_FAULTS + 1);
  localparam logic [IW-1:0]  INIT_LAST = IW'(DEB_CYCLES);
  localparam logic [EW-1:0]  ESC_LAST  = EW'(ESC_CYCLES - 1);
  localparam logic [FCW-1:0] FC_LAST   = FCW'(MAX_FAULTS - 1);
  localparam logic [FCW-1:0] FC_MAX    = FCW'(MAX_FAULTS);

  state_t         state, state_next;
  class_t         cls;
  logic           all_ok;
  logic           go_fault;
  logic           init_done;
  logic [IW-1:0]  init_cnt;
  logic [EW-1:0]  esc_cnt;

  for (genvar i = 0; i < N_SENS; i++) begin : g_deb
    absu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk (clk),
      .rst (rst),
      .raw (sens_raw[i]),
      .deb (sens_deb[i])
    );
  end

  always_comb begin
    cls.emg   = |(sens_deb & EMG_MASK);
    cls.fault = |(sens_deb & FAULT_MASK);
    cls.warn  = |(sens_deb & WARN_MASK);
    all_ok    = ~(cls.emg | cls.fault | cls.warn);
    init_done = (init_cnt == INIT_LAST);
  end

  // Every path into FAULT funnels through go_fault so counting and lockout stay in one place.
  always_comb begin
    state_next = state;
    go_fault   = 1'b0;
    case (state)
      S_INIT: begin
        if (init_done) begin
          if (cls.emg)        state_next = S_EMG;
          else if (cls.fault) go_fault   = 1'b1;
          else if (cls.warn)  state_next = S_WARN;
          else                state_next = S_NORMAL;
        end
      end
      S_NORMAL: begin
        if (cls.emg)        state_next = S_EMG;
        else if (cls.fault) go_fault   = 1'b1;
        else if (cls.warn)  state_next = S_WARN;
      end
      S_WARN: begin
        if (cls.emg)                             state_next = S_EMG;
        else if (cls.fault || esc_cnt == ESC_LAST) go_fault = 1'b1;
        else if (all_ok)                         state_next = S_NORMAL;
      end
      S_FAULT: begin
        if (cls.emg)     state_next = S_EMG;
        else if (all_ok) state_next = S_NORMAL;
      end
      S_EMG: begin
        if (emg_ack && !cls.emg) state_next = S_INIT;
      end
      default: state_next = S_LOCK;
    endcase
    if (go_fault) state_next = (fault_cnt == FC_LAST) ? S_LOCK : S_FAULT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      esc_cnt   <= '0;
      fault_cnt <= '0;
    end else begin
      state <= state_next;
      if (state != S_INIT)  init_cnt <= '0;
      else if (!init_done)  init_cnt <= init_cnt + IW'(1);
      esc_cnt <= (state == S_WARN && state_next == S_WARN) ? esc_cnt + EW'(1) : '0;
      if (go_fault && fault_cnt != FC_MAX) fault_cnt <= fault_cnt + FCW'(1);
    end
  end

  always_comb begin
    y_table     = 1'b0;
    y_gantry    = 1'b0;
    y_filter    = 1'b0;
    y_fan       = 1'b0;
    y_shutter   = 1'b0;
    y_relay_iso = 1'b0;
    case (state)
      S_INIT: begin
        y_shutter   = 1'b1;
        y_relay_iso = 1'b1;
      end
      S_NORMAL: begin
        y_table  = 1'b1;
        y_gantry = 1'b1;
        y_filter = 1'b1;
      end
      S_WARN: begin
        y_table  = 1'b1;
        y_filter = 1'b1;
        y_fan    = 1'b1;
        y_gantry = ~|(sens_deb & GANTRY_INH);
      end
      default: begin
        y_fan       = 1'b1;
        y_shutter   = 1'b1;
        y_relay_iso = 1'b1;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_adaptive_beam_safety_supervisor.sv
// Scenario bench for adaptive_beam_safety_supervisor: each step drives inputs,
// queues the expected snapshot and compares it after the given number of clocks.
module tb_adaptive_beam_safety_supervisor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] sens_raw = '0;
  logic       emg_ack = 1'b0;
  logic       y_table, y_gantry, y_filter, y_fan, y_shutter, y_relay_iso;
  logic [5:0] sens_deb;
  logic [1:0] fault_cnt;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] INIT = 3'd0, NORM = 3'd1, WARN = 3'd2, FLT = 3'd3, EMG = 3'd4, LOCK = 3'd5;

  typedef struct packed {
    logic        rst;
    logic [5:0]  raw;
    logic        ack;
    logic [10:0] n;
    logic [2:0]  st;
    logic [5:0]  deb;
    logic [1:0]  fc;
  } step_t;

  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  adaptive_beam_safety_supervisor dut (
    .clk         (clk),
    .rst         (rst),
    .sens_raw    (sens_raw),
    .emg_ack     (emg_ack),
    .y_table     (y_table),
    .y_gantry    (y_gantry),
    .y_filter    (y_filter),
    .y_fan       (y_fan),
    .y_shutter   (y_shutter),
    .y_relay_iso (y_relay_iso),
    .sens_deb    (sens_deb),
    .fault_cnt   (fault_cnt),
    .state_dbg   (state_dbg)
  );

  // Expected actuator vector {table,gantry,filter,fan,shutter,relay} for a state.
  function automatic logic [5:0] y_model(input logic [2:0] st, input logic [5:0] deb);
    case (st)
      INIT:    return 6'b000011;
      NORM:    return 6'b111000;
      WARN:    return {1'b1, ~deb[4], 1'b1, 1'b1, 2'b00};
      default: return 6'b000111;
    endcase
  endfunction

  function automatic logic [16:0] expv(input step_t s);
    return {s.st, y_model(s.st, s.deb), s.deb, s.fc};
  endfunction

  function automatic logic [16:0] obs();
    return {state_dbg, y_table, y_gantry, y_filter, y_fan, y_shutter, y_relay_iso, sens_deb, fault_cnt};
  endfunction

  function automatic step_t mk(input logic r, input logic [5:0] raw, input logic ack,
                               input int n, input logic [2:0] st, input logic [5:0] deb,
                               input logic [1:0] fc);
    return '{rst: r, raw: raw, ack: ack, n: 11'(n), st: st, deb: deb, fc: fc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    logic [16:0] e;
    s.push_back(mk(1, 6'h00, 0, 1, INIT, 6'h00, 0));
    s.push_back(mk(0, 6'h00, 0, 4, INIT, 6'h00, 0));
    s.push_back(mk(0, 6'h00, 0, 1, NORM, 6'h00, 0));
    foreach (s[i]) begin
      rst = s[i].rst; sens_raw = s[i].raw; emg_ack = s[i].ack;
      exp_q.push_back(expv(s[i]));
      repeat (int'(s[i].n)) tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL reset step %0d: got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_glitch();
    step_t s[$];
    logic [16:0] e;
    s.push_back(mk(0, 6'h01, 0, 3, NORM, 6'h00, 0));
    s.push_back(mk(0, 6'h00, 0, 5, NORM, 6'h00, 0));
    foreach (s[i]) begin
      rst = s[i].rst; sens_raw = s[i].raw; emg_ack = s[i].ack;
      exp_q.push_back(expv(s[i]));
      repeat (int'(s[i].n)) tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL glitch step %0d: got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_warn_escalation();
    step_t s[$];
    logic [16:0] e;
    s.push_back(mk(0, 6'h10, 0, 4,   NORM, 6'h10, 0));
    s.push_back(mk(0, 6'h10, 0, 1,   WARN, 6'h10, 0));
    s.push_back(mk(0, 6'h10, 0, 999, WARN, 6'h10, 0));
    s.push_back(mk(0, 6'h10, 0, 1,   FLT,  6'h10, 1));
    s.push_back(mk(0, 6'h00, 0, 4,   FLT,  6'h00, 1));
    s.push_back(mk(0, 6'h00, 0, 1,   NORM, 6'h00, 1));
    foreach (s[i]) begin
      rst = s[i].rst; sens_raw = s[i].raw; emg_ack = s[i].ack;
      exp_q.push_back(expv(s[i]));
      repeat (int'(s[i].n)) tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL warn_esc step %0d: got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_emg_ack();
    step_t s[$];
    logic [16:0] e;
    s.push_back(mk(0, 6'h02, 0, 4, NORM, 6'h02, 1));
    s.push_back(mk(0, 6'h00, 0, 1, EMG,  6'h02, 1));
    s.push_back(mk(0, 6'h00, 1, 1, EMG,  6'h02, 1));
    s.push_back(mk(0, 6'h00, 1, 2, EMG,  6'h00, 1));
    s.push_back(mk(0, 6'h00, 1, 1, INIT, 6'h00, 1));
    s.push_back(mk(0, 6'h00, 0, 4, INIT, 6'h00, 1));
    s.push_back(mk(0, 6'h00, 0, 1, NORM, 6'h00, 1));
    foreach (s[i]) begin
      rst = s[i].rst; sens_raw = s[i].raw; emg_ack = s[i].ack;
      exp_q.push_back(expv(s[i]));
      repeat (int'(s[i].n)) tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL emg_ack step %0d: got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_fault_lockout();
    step_t s[$];
    logic [16:0] e;
    s.push_back(mk(0, 6'h04, 0, 4, NORM, 6'h04, 1));
    s.push_back(mk(0, 6'h04, 0, 1, FLT,  6'h04, 2));
    s.push_back(mk(0, 6'h00, 0, 4, FLT,  6'h00, 2));
    s.push_back(mk(0, 6'h00, 0, 1, NORM, 6'h00, 2));
    s.push_back(mk(0, 6'h04, 0, 4, NORM, 6'h04, 2));
    s.push_back(mk(0, 6'h04, 0, 1, LOCK, 6'h04, 3));
    s.push_back(mk(0, 6'h00, 0, 8, LOCK, 6'h00, 3));
    s.push_back(mk(0, 6'h02, 0, 6, LOCK, 6'h02, 3));
    s.push_back(mk(0, 6'h00, 1, 6, LOCK, 6'h00, 3));
    foreach (s[i]) begin
      rst = s[i].rst; sens_raw = s[i].raw; emg_ack = s[i].ack;
      exp_q.push_back(expv(s[i]));
      repeat (int'(s[i].n)) tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL lockout step %0d: got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_reset_mid_warn();
    step_t s[$];
    logic [16:0] e;
    s.push_back(mk(1, 6'h00, 0, 1, INIT, 6'h00, 0));
    s.push_back(mk(0, 6'h00, 0, 5, NORM, 6'h00, 0));
    s.push_back(mk(0, 6'h08, 0, 4, NORM, 6'h08, 0));
    s.push_back(mk(0, 6'h08, 0, 1, WARN, 6'h08, 0));
    s.push_back(mk(1, 6'h08, 0, 1, INIT, 6'h00, 0));
    s.push_back(mk(0, 6'h08, 0, 4, INIT, 6'h08, 0));
    s.push_back(mk(0, 6'h08, 0, 1, WARN, 6'h08, 0));
    foreach (s[i]) begin
      rst = s[i].rst; sens_raw = s[i].raw; emg_ack = s[i].ack;
      exp_q.push_back(expv(s[i]));
      repeat (int'(s[i].n)) tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL rst_mid_warn step %0d: got %h want %h", i, obs(), e);
      end
    end
  endtask

  // Emergency and fault debounce on the same edge while in WARN: emergency must win.
  task automatic test_back_to_back();
    step_t s[$];
    logic [16:0] e;
    s.push_back(mk(0, 6'h0E, 0, 4, WARN, 6'h0E, 0));
    s.push_back(mk(0, 6'h0E, 0, 1, EMG,  6'h0E, 0));
    s.push_back(mk(0, 6'h0E, 1, 3, EMG,  6'h0E, 0));
    foreach (s[i]) begin
      rst = s[i].rst; sens_raw = s[i].raw; emg_ack = s[i].ack;
      exp_q.push_back(expv(s[i]));
      repeat (int'(s[i].n)) tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL back_to_back step %0d: got %h want %h", i, obs(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_warn_escalation();
    test_emg_ack();
    test_fault_lockout();
    test_reset_mid_warn();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
